led_pattern_sequencer: RTL and testbench

Sequences the 4-bit LED-pattern block-RAM ROM, which has a 12-bit address and one cycle of read latency. It steps the ROM address at a programmable rate, forward or backward with wrap-around, and drives the ROM enable. It captures each ROM word into a registered LED output. It sits between the board-level run/direction/speed controls and the pattern ROM.

---
 rtl/led_seq_pkg.sv | 17 +
 rtl/led_seq_prescaler.sv | 40 ++++
 rtl/led_pattern_sequencer.sv | 160 ++++++++++++++++
 tb/tb_led_pattern_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared types and defaults for the LED pattern sequencer.
package led_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 4;

endpackage

// File: rtl/led_seq_prescaler.sv
// Step-period counter: loads (PRESCALE_DIV << speed_sel) - 3, counts down on dec, flags terminal count.
// tc is combinational and is asserted only while dec is high and the count has reached zero.
module led_seq_prescaler #(
    parameter int PRESCALE_DIV = 50000000,
    parameter int CNT_W        = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       dec,
    input  logic [1:0] speed_sel,
    output logic       tc
);

    localparam logic [CNT_W-1:0] BASE = CNT_W'(PRESCALE_DIV);

    if (((longint'(PRESCALE_DIV) << 3) >> CNT_W) != 0) begin : g_cnt_w_too_small
        $error("led_seq_prescaler: PRESCALE_DIV << 3 does not fit in CNT_W bits");
    end
    if (PRESCALE_DIV < 3) begin : g_div_too_small
        $error("led_seq_prescaler: PRESCALE_DIV must be at least 3");
    end

    logic [CNT_W-1:0] cnt;

    // FETCH and CAPTURE account for two cycles of each period, the
    // terminal-count cycle for one more: hence the -3.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= (BASE << speed_sel) - CNT_W'(3);
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign tc = dec && (cnt == '0);

endmodule

// File: rtl/led_pattern_sequencer.sv
// Steps a 1-cycle-latency pattern ROM at a programmable rate and registers each word onto the LEDs.
// Optional LED_SEQ_BOUNCE_EN: ping-pong addressing instead of wrap-around.
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int LAST_ADDR    = 4095,
    parameter int PRESCALE_DIV = 50000000,
    parameter int CNT_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              dir,
    input  logic [1:0]        speed_sel,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] led,
    output logic              step_pulse,
    output logic              wrap
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

    state_t            state;
    state_t            state_nxt;
    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_tc;
    logic              advance;
    logic              step_dir;
    logic              end_hit;
    logic [ADDR_W-1:0] addr_adv;
    logic              wrap_pend;

    led_seq_prescaler #(
        .PRESCALE_DIV (PRESCALE_DIV),
        .CNT_W        (CNT_W)
    ) u_prescaler (
        .clk       (clk),
        .rst       (rst),
        .load      (cnt_load),
        .dec       (cnt_dec),
        .speed_sel (speed_sel),
        .tc        (cnt_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        advance   = 1'b0;
        case (state)
            IDLE: begin
                if (run) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                state_nxt = CAPTURE;
            end
            CAPTURE: begin
                cnt_load  = 1'b1;
                state_nxt = HOLD;
            end
            HOLD: begin
                cnt_dec = 1'b1;
                if (cnt_tc) begin
                    advance   = 1'b1;
                    state_nxt = run ? FETCH : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef LED_SEQ_BOUNCE_EN
    logic dir_q;

    // Direction is latched only when a run starts; reversals update it afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            dir_q <= DIR_UP;
        end else if ((state == IDLE) && run) begin
            dir_q <= dir;
        end else if (advance && end_hit) begin
            dir_q <= ~dir_q;
        end
    end

    assign step_dir = dir_q;
`else
    assign step_dir = dir;
`endif

    always_comb begin
        end_hit  = 1'b0;
        addr_adv = rom_addr;
        if (step_dir == DIR_UP) begin
            if (rom_addr == LAST) begin
                end_hit = 1'b1;
`ifdef LED_SEQ_BOUNCE_EN
                addr_adv = rom_addr - ADDR_W'(1);
`else
                addr_adv = '0;
`endif
            end else begin
                addr_adv = rom_addr + ADDR_W'(1);
            end
        end else begin
            if (rom_addr == '0) begin
                end_hit = 1'b1;
`ifdef LED_SEQ_BOUNCE_EN
                addr_adv = ADDR_W'(1);
`else
                addr_adv = LAST;
`endif
            end else begin
                addr_adv = rom_addr - ADDR_W'(1);
            end
        end
    end

    // wrap_pend carries the end-of-range event from the advance to the next displayed step.
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr   <= '0;
            led        <= '0;
            step_pulse <= 1'b0;
            wrap       <= 1'b0;
            wrap_pend  <= 1'b0;
        end else begin
            step_pulse <= (state == CAPTURE);
            wrap       <= (state == CAPTURE) && wrap_pend;
            if (state == CAPTURE) begin
                led       <= rom_data;
                wrap_pend <= 1'b0;
            end
            if (advance) begin
                rom_addr  <= addr_adv;
                wrap_pend <= end_hit;
            end
        end
    end

    assign rom_en = (state == FETCH);

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench: PRESCALE_DIV=4, LAST_ADDR=7, one-hot ROM pattern 8,4,2,1 by addr[1:0].
module tb_led_pattern_sequencer;

    localparam int ADDR_W       = 12;
    localparam int DATA_W       = 4;
    localparam int LAST_ADDR    = 7;
    localparam int PRESCALE_DIV = 4;
    localparam int CNT_W        = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              run;
    logic              dir;
    logic [1:0]        speed_sel;
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data = '0;
    logic [DATA_W-1:0] led;
    logic              step_pulse;
    logic              wrap;

    int tests_run    = 0;
    int tests_failed = 0;

    led_pattern_sequencer #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .LAST_ADDR    (LAST_ADDR),
        .PRESCALE_DIV (PRESCALE_DIV),
        .CNT_W        (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .dir        (dir),
        .speed_sel  (speed_sel),
        .rom_en     (rom_en),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .led        (led),
        .step_pulse (step_pulse),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    // Block-RAM model: one cycle of latency, output forced to zero when disabled.
    always @(posedge clk) begin
        rom_data <= rom_en ? (4'b1000 >> rom_addr[1:0]) : 4'b0000;
    end

    function automatic logic [3:0] pat(input int a);
        return 4'b1000 >> (a % 4);
    endfunction

    // Waits for the next step_pulse, counting negedges and rom_en-high cycles on the way.
    task automatic wait_step(input int budget, output int cycles, output int en_cycles, output bit ok);
        cycles    = 0;
        en_cycles = 0;
        ok        = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            cycles++;
            if (rom_en) en_cycles++;
            if (step_pulse) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        run       = 1'b0;
        dir       = 1'b0;
        speed_sel = 2'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One step: timing (cycles since last call, rom_en cycles) and content (addr, led, wrap).
    task automatic expect_step(input string name, input int exp_cyc, input int exp_addr, input bit exp_wrap);
        int cyc, en;
        bit ok;
        logic [15:0] got_t, exp_t;
        logic [16:0] got_c, exp_c;
        wait_step(64, cyc, en, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL %s timeout: no step_pulse within 64 cycles, required one after %0d", name, exp_cyc);
            return;
        end
        got_t = {cyc[7:0], en[7:0]};
        exp_t = {exp_cyc[7:0], 8'd1};
        if (got_t !== exp_t) begin
            tests_failed++;
            $display("FAIL %s timing: cycles=%0d rom_en_cycles=%0d, required cycles=%0d rom_en_cycles=1",
                     name, cyc, en, exp_cyc);
        end
        tests_run++;
        got_c = {rom_addr, led, wrap};
        exp_c = {ADDR_W'(exp_addr), pat(exp_addr), exp_wrap};
        if (got_c !== exp_c) begin
            tests_failed++;
            $display("FAIL %s content: addr=%0d led=%h wrap=%b, required addr=%0d led=%h wrap=%b",
                     name, rom_addr, led, wrap, exp_addr, pat(exp_addr), exp_wrap);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        run       = 1'b1;
        dir       = 1'b0;
        speed_sel = 2'd0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({rom_en, rom_addr, led, step_pulse, wrap} !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: rom_en=%b addr=%0d led=%h step=%b wrap=%b, required all 0",
                     rom_en, rom_addr, led, step_pulse, wrap);
        end
        rst = 1'b0;
        run = 1'b0;
    endtask

    task automatic test_forward();
        do_reset();
        run = 1'b1;
        for (int k = 0; k < 10; k++) begin
            expect_step($sformatf("forward[%0d]", k), (k == 0) ? 3 : 4, k % 8, k == 8);
        end
    endtask

    task automatic test_reverse();
        do_reset();
        dir = 1'b1;
        run = 1'b1;
        for (int k = 0; k < 10; k++) begin
            expect_step($sformatf("reverse[%0d]", k), (k == 0) ? 3 : 4, (8 - (k % 8)) % 8, k == 1 || k == 9);
        end
    endtask

    task automatic test_speed();
        do_reset();
        speed_sel = 2'd2;
        run       = 1'b1;
        expect_step("speed_first", 3, 0, 1'b0);
        expect_step("speed_x4", 16, 1, 1'b0);
        speed_sel = 2'd0;
        expect_step("speed_change_kept", 16, 2, 1'b0);
        expect_step("speed_change_applied", 4, 3, 1'b0);
    endtask

    task automatic test_pause_resume();
        int steps_seen = 0;
        int en_seen    = 0;
        do_reset();
        run = 1'b1;
        for (int k = 0; k < 4; k++) begin
            expect_step($sformatf("pause_pre[%0d]", k), (k == 0) ? 3 : 4, k, 1'b0);
        end
        run = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (step_pulse) steps_seen++;
            if (rom_en && steps_seen == 0) en_seen++;
        end
        tests_run++;
        if (steps_seen != 0 || en_seen != 0 || led !== 4'h1 || rom_addr !== ADDR_W'(4) || rom_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL pause_idle: steps=%0d en=%0d led=%h addr=%0d rom_en=%b, required 0 0 1 4 0",
                     steps_seen, en_seen, led, rom_addr, rom_en);
        end
        run = 1'b1;
        expect_step("resume_first", 3, 4, 1'b0);
        expect_step("resume_next", 4, 5, 1'b0);
    endtask

    task automatic test_reset_mid_hold();
        int en_seen = 0;
        do_reset();
        run = 1'b1;
        for (int k = 0; k < 6; k++) begin
            expect_step($sformatf("rst_pre[%0d]", k), (k == 0) ? 3 : 4, k, 1'b0);
        end
        rst = 1'b1;
        run = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({rom_en, rom_addr, led, step_pulse, wrap} !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid_hold: rom_en=%b addr=%0d led=%h step=%b wrap=%b, required all 0",
                     rom_en, rom_addr, led, step_pulse, wrap);
        end
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (rom_en || step_pulse) en_seen++;
        end
        tests_run++;
        if (en_seen != 0) begin
            tests_failed++;
            $display("FAIL reset_then_idle: activity cycles=%0d, required 0", en_seen);
        end
        run = 1'b1;
        expect_step("reset_restart", 3, 0, 1'b0);
    endtask

    task automatic test_dir_change();
        do_reset();
        run = 1'b1;
        expect_step("dirchg[0]", 3, 0, 1'b0);
        expect_step("dirchg[1]", 4, 1, 1'b0);
        expect_step("dirchg[2]", 4, 2, 1'b0);
        dir = 1'b1;
        expect_step("dirchg[3]", 4, 1, 1'b0);
        expect_step("dirchg[4]", 4, 0, 1'b0);
        expect_step("dirchg[5]", 4, 7, 1'b1);
    endtask

    initial begin
        test_reset();
        test_forward();
        test_reverse();
        test_speed();
        test_pause_resume();
        test_reset_mid_hold();
        test_dir_change();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
